mem_rd_bank: RTL and testbench

Banked activation/weight buffer that sits directly downstream of the skewed read controller: one independent single-read-port bank per systolic-array row. Each bank takes that row's per-cycle read enable and address and returns registered data with a fixed 2-cycle latency, so the row skew imposed upstream is preserved at the array input. A single host write port loads any bank while reads are in flight.

---
 rtl/mem_rd_bank_if.sv | 29 ++
 rtl/mem_rd_bank.sv | 93 +++++++++
 tb/tb_mem_rd_bank.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_rd_bank_if.sv
// Read/write bundle of the banked row buffer: per-row read strobes/addresses, host write port and read results.
// The array-side controller and host drive through master; the buffer itself uses slave.
interface mem_rd_bank_if #(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  localparam int ROW_W = (SYS_ROW > 1) ? $clog2(SYS_ROW) : 1;

  logic [SYS_ROW-1:0]    rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr [SYS_ROW];
  logic                  wr_en;
  logic [ROW_W-1:0]      wr_row;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [SYS_ROW-1:0]    rd_valid;
  logic [DATA_WIDTH-1:0] rd_data [SYS_ROW];
  logic                  oob_err;

  modport master (
    output rd_en, rd_addr, wr_en, wr_row, wr_addr, wr_data,
    input  rd_valid, rd_data, oob_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_row, wr_addr, wr_data,
    output rd_valid, rd_data, oob_err
  );
endinterface

// File: rtl/mem_rd_bank.sv
// Per-row read banks, 2-stage registered read (fixed 2-cycle latency, no backpressure), shared host write port.
// MEM_BANK_WR_BYPASS_EN selects write-first on a same-bank/same-address collision; default is read-first.
module mem_rd_bank #(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic         clk,
  input  logic         rst,
  mem_rd_bank_if.slave bus
);
  localparam int ROW_W = (SYS_ROW > 1) ? $clog2(SYS_ROW) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ROW_W:0]      ROW_LIM   = (ROW_W+1)'(SYS_ROW);

  logic [DATA_WIDTH-1:0] mem [SYS_ROW][DEPTH];

  logic [SYS_ROW-1:0]    v1;
  logic [DATA_WIDTH-1:0] d1 [SYS_ROW];

  logic [SYS_ROW-1:0]    rd_ok;
  logic [SYS_ROW-1:0]    rd_oob;
  logic [IDX_W-1:0]      rd_idx [SYS_ROW];
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_bad;
  logic                  wr_ok;
  logic                  wr_oob;
`ifdef MEM_BANK_WR_BYPASS_EN
  logic [SYS_ROW-1:0]    hit;
`endif

  // Range checks are done on the full address so aliased high bits never reach the array index.
  always_comb begin
    wr_idx = bus.wr_addr[IDX_W-1:0];
    wr_bad = ({1'b0, bus.wr_addr} >= DEPTH_LIM) || ({1'b0, bus.wr_row} >= ROW_LIM);
    wr_ok  = bus.wr_en && !wr_bad;
    wr_oob = bus.wr_en && wr_bad;
    for (int i = 0; i < SYS_ROW; i++) begin
      rd_idx[i] = bus.rd_addr[i][IDX_W-1:0];
      rd_ok[i]  = bus.rd_en[i] && ({1'b0, bus.rd_addr[i]} <  DEPTH_LIM);
      rd_oob[i] = bus.rd_en[i] && ({1'b0, bus.rd_addr[i]} >= DEPTH_LIM);
    end
  end

`ifdef MEM_BANK_WR_BYPASS_EN
  always_comb begin
    hit = '0;
    for (int i = 0; i < SYS_ROW; i++) begin
      hit[i] = wr_ok && (bus.wr_row == ROW_W'(i)) && (bus.wr_addr == bus.rd_addr[i]);
    end
  end
`endif

  // Storage is deliberately not reset; only the write itself is suppressed during reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[bus.wr_row][wr_idx] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1           <= '0;
      bus.rd_valid <= '0;
      bus.oob_err  <= 1'b0;
      for (int i = 0; i < SYS_ROW; i++) begin
        d1[i]          <= '0;
        bus.rd_data[i] <= '0;
      end
    end else begin
      v1           <= bus.rd_en;
      bus.rd_valid <= v1;
      for (int i = 0; i < SYS_ROW; i++) begin
        // d1 only moves on an enabled read, so rd_data holds its last value while idle.
        if (rd_ok[i]) begin
`ifdef MEM_BANK_WR_BYPASS_EN
          d1[i] <= hit[i] ? bus.wr_data : mem[i][rd_idx[i]];
`else
          d1[i] <= mem[i][rd_idx[i]];
`endif
        end else if (rd_oob[i]) begin
          d1[i] <= '0;
        end
        bus.rd_data[i] <= d1[i];
      end
      if ((|rd_oob) || wr_oob) begin
        bus.oob_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_rd_bank.sv
// Directed bench for mem_rd_bank with a reference memory and an output scoreboard checked every cycle.
module tb_mem_rd_bank;
  localparam int SR = 12;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DP = 128;
  localparam int RW = 4;

  typedef struct packed {
    logic [SR-1:0]         vld;
    logic [SR-1:0][DW-1:0] dat;
  } exp_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  exp_t                  q[$];
  logic [DW-1:0]         mem_m [SR][256];
  logic [SR-1:0][DW-1:0] d1m;
  logic                  oob_m;

  mem_rd_bank_if #(.SYS_ROW(SR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_rd_bank #(.SYS_ROW(SR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: update the reference at the edge, then compare outputs 1 time unit later.
  task automatic step();
    exp_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      d1m   = '0;
      oob_m = 1'b0;
      e     = '0;
      q.push_back(e);
      q.push_back(e);
    end else begin
      for (int i = 0; i < SR; i++) begin
        if (bus.rd_en[i]) begin
          if (int'(bus.rd_addr[i]) >= DP) begin
            d1m[i] = '0;
            oob_m  = 1'b1;
          end
`ifdef MEM_BANK_WR_BYPASS_EN
          else if (bus.wr_en && int'(bus.wr_row) == i && bus.wr_addr == bus.rd_addr[i]) d1m[i] = bus.wr_data;
`endif
          else d1m[i] = mem_m[i][bus.rd_addr[i]];
        end
      end
      if (bus.wr_en) begin
        if (int'(bus.wr_row) >= SR || int'(bus.wr_addr) >= DP) oob_m = 1'b1;
        else mem_m[bus.wr_row][bus.wr_addr] = bus.wr_data;
      end
      e.vld = bus.rd_en;
      e.dat = d1m;
      q.push_back(e);
    end
    #1;
    e = q.pop_front();
    chk("rd_valid", 32'(bus.rd_valid), 32'(e.vld));
    for (int i = 0; i < SR; i++) begin
      chk($sformatf("rd_data[%0d]", i), 32'(bus.rd_data[i]), 32'(e.dat[i]));
    end
    chk("oob_err", 32'(bus.oob_err), 32'(oob_m));
  endtask

  task automatic idle();
    bus.rd_en  = '0;
    bus.wr_en  = 1'b0;
    for (int i = 0; i < SR; i++) bus.rd_addr[i] = '1;
  endtask

  task automatic wr(input int row, input int addr, input logic [DW-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_row  = RW'(row);
    bus.wr_addr = AW'(addr);
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < SR; r++)
      for (int a = 0; a < 256; a++) mem_m[r][a] = 'x;
    d1m   = '0;
    oob_m = 1'b0;
    bus.wr_row  = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Single read from bank 3.
    wr(3, 'h10, 16'hBEEF);
    step();
    bus.rd_en[3]   = 1'b1;
    bus.rd_addr[3] = 8'h10;
    step();
    idle();
    step();
    step();

    // Load {row, addr} patterns, then read with upstream-style row skew.
    for (int i = 0; i < SR; i++)
      for (int k = 0; k < 4; k++) wr(i, k, DW'((i << 8) | k));
    for (int c = 0; c < SR + 3; c++) begin
      for (int i = 0; i < SR; i++) begin
        if (c >= i && c < i + 4) begin
          bus.rd_en[i]   = 1'b1;
          bus.rd_addr[i] = AW'(c - i);
        end else begin
          bus.rd_en[i]   = 1'b0;
          bus.rd_addr[i] = '1;
        end
      end
      step();
    end
    idle();
    step();
    step();

    // Same-cycle write and read of bank 5 address 0x20, then a plain re-read.
    wr(5, 'h20, 16'h1111);
    bus.rd_en[5]   = 1'b1;
    bus.rd_addr[5] = 8'h20;
    wr(5, 'h20, 16'h2222);
    step();
    idle();
    step();
    step();

    // Out-of-range read and write.
    bus.rd_en[0]   = 1'b1;
    bus.rd_addr[0] = 8'h90;
    step();
    idle();
    step();
    wr(SR, 'h01, 16'hAAAA);
    wr(1, 'h90, 16'hBBBB);
    step();
    step();

    // All banks read, reset lands one cycle later with a write that must be dropped.
    for (int i = 0; i < SR; i++) begin
      bus.rd_en[i]   = 1'b1;
      bus.rd_addr[i] = 8'h01;
    end
    step();
    idle();
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_row  = RW'(3);
    bus.wr_addr = 8'h10;
    bus.wr_data = 16'hDEAD;
    step();
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    step();
    step();

    // Contents survive reset.
    for (int i = 0; i < SR; i++) begin
      bus.rd_en[i]   = 1'b1;
      bus.rd_addr[i] = 8'h02;
    end
    step();
    idle();
    bus.rd_en[3]   = 1'b1;
    bus.rd_addr[3] = 8'h10;
    step();
    idle();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
